// File: rtl/burst_pkt_pkg.sv
// burst_pkt_pkg: opcodes, FSM states and STATUS word layout for the burst packet engine
package burst_pkt_pkg;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam int STAT_W = 16;
  localparam int STAT_PKT_LSB = 0;
  localparam int STAT_ERR_LSB = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_WR,
    S_RD,
    S_SUM,
    S_STAT
  } state_e;
  function automatic logic [STAT_W-1:0] status_word(input logic [7:0] err, input logic [7:0] pkt);
    logic [STAT_W-1:0] w;
    w = '0;
    w[STAT_ERR_LSB +: 8] = err;
    w[STAT_PKT_LSB +: 8] = pkt;
    return w;
  endfunction
endpackage

// File: rtl/burst_buf_ram.sv
// burst_buf_ram: simple dual-port RAM with one write port and a registered 1-cycle read port
module burst_buf_ram #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/burst_packet_engine.sv
// burst_packet_engine: parses WRITE/READ/STATUS packets from the RX stream and answers on the TX stream
module burst_packet_engine
  import burst_pkt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             abort,
  output logic             busy,
  output logic [7:0]       pkt_count,
  output logic [7:0]       err_count
);
  localparam int CW = (WIDTH > ADDR_W ? WIDTH : ADDR_W) + 2;
  state_e state_q, state_d;
  logic rd_op_q, rd_op_d;
  logic [ADDR_W:0] len_q, len_d, cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d, stat_q, stat_d, ram_q;
  logic [7:0] pkt_q, pkt_d, err_q, err_d;
  logic rx_fire, tx_fire, err_inc, clamp, we, re;
  logic [CW-1:0] n_ext;
  logic [ADDR_W-1:0] raddr;
  assign rx_ready = !rst && (state_q inside {S_IDLE, S_LEN, S_WR});
  assign tx_valid = state_q inside {S_RD, S_SUM, S_STAT};
  assign tx_data = state_q == S_RD ? ram_q : state_q == S_SUM ? sum_q : state_q == S_STAT ? stat_q : '0;
  assign busy = state_q != S_IDLE;
  assign pkt_count = pkt_q;
  assign err_count = err_q;
  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  assign n_ext = CW'(rx_data);
  assign clamp = n_ext > CW'(BUF_DEPTH);
  assign we = state_q == S_WR && rx_fire && !abort;
  // Prefetch word 0 while waiting for LEN, then fetch ahead only on a TX handshake so stalls hold the output.
  assign re = state_q != S_RD || tx_ready;
  assign raddr = state_q == S_RD ? cnt_q[ADDR_W-1:0] + ADDR_W'(1) : '0;
  burst_buf_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_buf (
    .clk(clk),
    .we_i(we),
    .waddr_i(cnt_q[ADDR_W-1:0]),
    .wdata_i(rx_data),
    .re_i(re),
    .raddr_i(raddr),
    .rdata_o(ram_q)
  );
  always_comb begin
    state_d = state_q;
    rd_op_d = rd_op_q;
    len_d = len_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    stat_d = stat_q;
    pkt_d = pkt_q;
    err_inc = 1'b0;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        if (rx_data[7:0] == OP_WRITE || rx_data[7:0] == OP_READ) begin
          state_d = S_LEN;
          rd_op_d = rx_data[7:0] == OP_READ;
        end else if (rx_data[7:0] == OP_STATUS) begin
          state_d = S_STAT;
          stat_d = WIDTH'(status_word(err_q, pkt_q));
        end else err_inc = 1'b1;
      end
      S_LEN: if (rx_fire) begin
        len_d = clamp ? (ADDR_W+1)'(BUF_DEPTH) : n_ext[ADDR_W:0];
        err_inc = clamp;
        cnt_d = '0;
        sum_d = '0;
        state_d = len_d == '0 ? S_SUM : rd_op_q ? S_RD : S_WR;
      end
      S_WR: if (rx_fire) begin
        sum_d = sum_q + rx_data;
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        state_d = cnt_d == len_q ? S_SUM : S_WR;
      end
      S_RD: if (tx_fire) begin
        sum_d = sum_q + ram_q;
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        state_d = cnt_d == len_q ? S_SUM : S_RD;
      end
      S_SUM, S_STAT: if (tx_fire) begin
        pkt_d = pkt_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_inc && err_q != 8'hFF ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_op_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      stat_q <= '0;
      pkt_q <= '0;
      err_q <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
      rd_op_q <= rd_op_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      stat_q <= stat_d;
      pkt_q <= pkt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_burst_packet_engine.sv
// tb_burst_packet_engine: directed packets on 32-bit and 8-bit engines checked against a packet-level model
module tb_burst_packet_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic tx_ready = 1'b0;
  logic [1:0] rx_valid = '0;
  logic [1:0] rx_ready, tx_valid, busy;
  logic [31:0] rxd0 = '0, rxd1 = '0, tx32;
  logic [7:0] tx8, pkt0, pkt1, err0, err1;
  int checks = 0, failures = 0;
  int cur = 0, mode = 0;
  bit chk_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0, last_tx = '0;
  logic [31:0] exp_q [$];
  logic [31:0] mbuf [2][256];
  int mpkt [2], merr [2];
  always #5 clk = ~clk;
  burst_packet_engine #(.WIDTH(32), .BUF_DEPTH(256), .ADDR_W(8)) dut32 (
    .clk(clk), .rst(rst), .rx_data(rxd0), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_data(tx32), .tx_valid(tx_valid[0]), .tx_ready(tx_ready), .abort(abort),
    .busy(busy[0]), .pkt_count(pkt0), .err_count(err0)
  );
  burst_packet_engine #(.WIDTH(8), .BUF_DEPTH(256), .ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .rx_data(rxd1[7:0]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .tx_data(tx8), .tx_valid(tx_valid[1]), .tx_ready(tx_ready), .abort(abort),
    .busy(busy[1]), .pkt_count(pkt1), .err_count(err1)
  );
  function automatic logic [31:0] txd(input int d);
    return d != 0 ? {24'h0, tx8} : tx32;
  endfunction
  function automatic logic [7:0] pc(input int d);
    return d != 0 ? pkt1 : pkt0;
  endfunction
  function automatic logic [7:0] ec(input int d);
    return d != 0 ? err1 : err0;
  endfunction
  function automatic logic [31:0] mk(input int d);
    return d != 0 ? 32'hFF : 32'hFFFF_FFFF;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    tx_ready = mode == 0 ? 1'b1 : mode == 1 ? ~tx_ready : 1'b0;
    if (chk_en) begin
      if (prev_stall) begin
        chk("tx_hold_valid", tx_valid[cur], 1);
        chk("tx_hold_data", txd(cur), prev_data);
      end
      if (tx_valid[cur]) chk("tx_not_while_rx", rx_ready[cur], 0);
      if (tx_valid[1-cur]) chk("idle_dut_tx", tx_valid[1-cur], 0);
      if (tx_valid[cur] && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%h expected=none", txd(cur));
        end else chk("tx_word", txd(cur), exp_q.pop_front());
        last_tx = txd(cur);
      end
    end
    prev_stall = chk_en && tx_valid[cur] && !tx_ready;
    prev_data = txd(cur);
  end
  task automatic send(input int d, input logic [31:0] w);
    int t = 0;
    @(negedge clk);
    rx_valid[d] = 1'b1;
    if (d != 0) rxd1 = w; else rxd0 = w;
    while (!rx_ready[d] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout actual=stuck expected=rx_ready");
    end
    @(negedge clk);
    rx_valid[d] = 1'b0;
  endtask
  task automatic err_up(input int d);
    if (merr[d] < 255) merr[d]++;
  endtask
  task automatic drain(input int d);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_left expected=0_left", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("busy_idle", busy[d], 0);
    chk("pkt_count", pc(d), mpkt[d]);
    chk("err_count", ec(d), merr[d]);
  endtask
  task automatic pkt_write(input int d, input logic [31:0] n, input logic [31:0] ws [$]);
    logic [31:0] s = '0;
    int len = n > 256 ? 256 : int'(n);
    if (n > 256) err_up(d);
    for (int i = 0; i < len; i++) begin
      mbuf[d][i] = ws[i] & mk(d);
      s = (s + ws[i]) & mk(d);
    end
    exp_q.push_back(s);
    mpkt[d] = (mpkt[d] + 1) % 256;
    send(d, 1);
    send(d, n);
    for (int i = 0; i < len; i++) send(d, ws[i]);
    drain(d);
  endtask
  task automatic pkt_read(input int d, input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mbuf[d][i]);
      s = (s + mbuf[d][i]) & mk(d);
    end
    exp_q.push_back(s);
    mpkt[d] = (mpkt[d] + 1) % 256;
    send(d, 2);
    send(d, n);
    drain(d);
  endtask
  task automatic pkt_status(input int d);
    exp_q.push_back(((merr[d] << 8) | mpkt[d]) & mk(d));
    mpkt[d] = (mpkt[d] + 1) % 256;
    send(d, 3);
    drain(d);
  endtask
  task automatic pkt_bad(input int d, input logic [31:0] op);
    err_up(d);
    send(d, op);
    drain(d);
  endtask
  initial begin
    logic [31:0] ws [$];
    int t;
    mpkt = '{0, 0};
    merr = '{0, 0};
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rx_ready", rx_ready[d], 0);
      chk("rst_tx_valid", tx_valid[d], 0);
      chk("rst_tx_data", txd(d), 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_pkt", pc(d), 0);
      chk("rst_err", ec(d), 0);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    cur = 0;
    ws = '{32'h1, 32'h2, 32'h3, 32'hFFFF_FFFF};
    pkt_write(0, 4, ws);
    chk("w4_sum_lit", last_tx, 32'h5);
    chk("w4_pkt_lit", pkt0, 8'd1);
    mode = 1;
    pkt_read(0, 4);
    chk("r4_sum_lit", last_tx, 32'h5);
    chk("r4_pkt_lit", pkt0, 8'd2);
    mode = 0;
    ws.delete();
    pkt_write(0, 0, ws);
    chk("w0_sum_lit", last_tx, 32'h0);
    pkt_bad(0, 32'h7F);
    chk("bad_err_lit", err0, 8'd1);
    pkt_status(0);
    chk("status_lit", last_tx, 32'h0000_0103);
    for (int i = 0; i < 300; i++) ws.push_back(32'h0101_0000 * i + 32'd7);
    pkt_write(0, 300, ws);
    chk("clamp_err_lit", err0, 8'd2);
    pkt_status(0);
    chk("status2_lit", last_tx, 32'h0000_0205);
    send(0, 1);
    send(0, 4);
    send(0, 32'hA5A5_0001);
    send(0, 32'h5A5A_0002);
    mbuf[0][0] = 32'hA5A5_0001;
    mbuf[0][1] = 32'h5A5A_0002;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy[0], 0);
    drain(0);
    chk("abort_pkt_lit", pkt0, 8'd6);
    pkt_read(0, 2);
    chk("abort_rd_sum_lit", last_tx, 32'hFFFF_0003);
    cur = 1;
    ws = '{32'h80, 32'h80, 32'h01};
    pkt_write(1, 3, ws);
    chk("w8_sum_lit", last_tx, 32'h01);
    mode = 2;
    send(1, 2);
    send(1, 3);
    t = 0;
    while (!tx_valid[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rd8_first_word", txd(1), 32'h80);
    chk_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rx_ready", rx_ready[1], 0);
    chk("mid_rst_tx_valid", tx_valid[1], 0);
    chk("mid_rst_tx_data", txd(1), 0);
    chk("mid_rst_busy", busy[1], 0);
    chk("mid_rst_pkt", pkt1, 0);
    chk("mid_rst_err", err1, 0);
    rst = 1'b0;
    mpkt = '{0, 0};
    merr = '{0, 0};
    exp_q.delete();
    mode = 0;
    @(negedge clk);
    chk_en = 1'b1;
    ws = '{32'h05};
    pkt_write(1, 1, ws);
    chk("w8b_sum_lit", last_tx, 32'h05);
    pkt_bad(1, 32'h7F);
    pkt_status(1);
    chk("status8_lit", last_tx, 32'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
